resonator_ddc_deadlock_watchdog: RTL and testbench

- Supervises the resonator DDC control core.
- Qualifies raw AXIS block indications against a programmable persistence threshold, then latches a sticky deadlock report with the offending stream mask.
- When enabled, sequences recovery: a timed soft-reset pulse to the core, then a cooldown window.
- Sits between the core's per-stream block/idle indications and the status/control register bank.

---
 rtl/resonator_ddc_watchdog_pkg.sv | 29 ++
 rtl/resonator_ddc_watchdog_run_counter.sv | 44 ++++
 rtl/resonator_ddc_deadlock_watchdog.sv | 159 +++++++++++++++
 tb/tb_resonator_ddc_deadlock_watchdog.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/resonator_ddc_watchdog_pkg.sv
// resonator_ddc_watchdog_pkg: shared state encoding, default sizes and helpers for the DDC deadlock watchdog.
// rev 1.0
`default_nettype none

package resonator_ddc_watchdog_pkg;

  localparam int N_AXIS_DEFAULT     = 4;
  localparam int THRESH_W_DEFAULT   = 16;
  localparam int RST_CYCLES_DEFAULT = 16;
  localparam int CNT_W_DEFAULT      = 16;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WATCH    = 3'd1,
    ST_DEADLOCK = 3'd2,
    ST_RECOVER  = 3'd3,
    ST_COOLDOWN = 3'd4
  } wd_state_e;

  // Increment v, holding at the all-ones value of a w-bit field (w <= 32).
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [63:0] max_val;
    max_val = (64'd1 << w) - 64'd1;
    return (64'(v) >= max_val) ? v : v + 32'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/resonator_ddc_watchdog_run_counter.sv
// resonator_ddc_watchdog_run_counter: saturating run-length counter with a next-value threshold match.
// rev 1.0
`default_nettype none

module resonator_ddc_watchdog_run_counter
  import resonator_ddc_watchdog_pkg::*;
#(
  parameter int THRESH_W = THRESH_W_DEFAULT
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                clear,
  input  logic                enable,
  input  logic [THRESH_W-1:0] threshold,
  output logic                hit
);

  logic [THRESH_W-1:0] count_q;
  logic [THRESH_W-1:0] count_d;
  logic [THRESH_W-1:0] count_inc;

  always_comb begin
    count_inc = THRESH_W'(sat_inc(32'(count_q), THRESH_W));
    count_d   = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_inc;
    end
    // Match on the value being written so deadlock lands on the T-th counted edge.
    hit = enable && !clear && (threshold != '0) && (count_inc == threshold);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/resonator_ddc_deadlock_watchdog.sv
// resonator_ddc_deadlock_watchdog: qualifies AXIS block indications, latches a sticky deadlock report and sequences soft-reset recovery.
// rev 1.0
`default_nettype none

module resonator_ddc_deadlock_watchdog
  import resonator_ddc_watchdog_pkg::*;
#(
  parameter int N_AXIS     = N_AXIS_DEFAULT,
  parameter int THRESH_W   = THRESH_W_DEFAULT,
  parameter int RST_CYCLES = RST_CYCLES_DEFAULT,
  parameter int CNT_W      = CNT_W_DEFAULT
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [N_AXIS-1:0]   axis_block_sigs,
  input  logic                inst_idle,
  input  logic [THRESH_W-1:0] threshold,
  input  logic                recover_en,
  input  logic                clear_status,
  output logic                block,
  output logic                deadlock,
  output logic [N_AXIS-1:0]   blocked_mask,
  output logic [CNT_W-1:0]    deadlock_count,
  output logic                core_soft_reset,
  output logic                busy
);

  localparam int PH_W = $clog2(RST_CYCLES + 1);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(RST_CYCLES - 1);

  wd_state_e          state_q, state_d;
  logic [N_AXIS-1:0]  sigs_q;
  logic               idle_q;
  logic [PH_W-1:0]    phase_q, phase_d;
  logic               deadlock_q, deadlock_d;
  logic [N_AXIS-1:0]  mask_q, mask_d;
  logic [CNT_W-1:0]   dl_count_q, dl_count_d;
  logic               soft_rst_q, soft_rst_d;

  logic any_blk;
  logic cnt_active;
  logic hit;
  logic entry;

  assign any_blk    = (|sigs_q) & ~idle_q;
  assign cnt_active = (state_q == ST_IDLE) || (state_q == ST_WATCH);

  resonator_ddc_watchdog_run_counter #(
    .THRESH_W (THRESH_W)
  ) u_run_counter (
    .clock     (clock),
    .reset     (reset),
    .clear     (!cnt_active || !any_blk),
    .enable    (any_blk),
    .threshold (threshold),
    .hit       (hit)
  );

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    entry   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (hit) begin
          state_d = ST_DEADLOCK;
          entry   = 1'b1;
        end else if (any_blk) begin
          state_d = ST_WATCH;
        end
      end
      ST_WATCH: begin
        if (!any_blk) begin
          state_d = ST_IDLE;
        end else if (hit) begin
          state_d = ST_DEADLOCK;
          entry   = 1'b1;
        end
      end
      ST_DEADLOCK: begin
        if (recover_en) begin
          state_d = ST_RECOVER;
          phase_d = '0;
        end else if (!any_blk) begin
          state_d = ST_IDLE;
        end
      end
      ST_RECOVER: begin
        if (phase_q == PH_LAST) begin
          state_d = ST_COOLDOWN;
          phase_d = '0;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      ST_COOLDOWN: begin
        if (phase_q == PH_LAST) begin
          state_d = ST_IDLE;
          phase_d = '0;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        phase_d = '0;
      end
    endcase

    deadlock_d = deadlock_q;
    mask_d     = mask_q;
    dl_count_d = dl_count_q;
    if (clear_status) begin
      deadlock_d = 1'b0;
      mask_d     = '0;
      dl_count_d = '0;
    end
    // A coincident clear is overridden by the entry, leaving a count of one.
    if (entry) begin
      deadlock_d = 1'b1;
      mask_d     = sigs_q;
      dl_count_d = clear_status ? CNT_W'(1) : CNT_W'(sat_inc(32'(dl_count_q), CNT_W));
    end

    soft_rst_d = (state_d == ST_RECOVER);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      sigs_q     <= '0;
      idle_q     <= 1'b0;
      phase_q    <= '0;
      deadlock_q <= 1'b0;
      mask_q     <= '0;
      dl_count_q <= '0;
      soft_rst_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sigs_q     <= axis_block_sigs;
      idle_q     <= inst_idle;
      phase_q    <= phase_d;
      deadlock_q <= deadlock_d;
      mask_q     <= mask_d;
      dl_count_q <= dl_count_d;
      soft_rst_q <= soft_rst_d;
    end
  end

  assign block           = |sigs_q;
  assign deadlock        = deadlock_q;
  assign blocked_mask    = mask_q;
  assign deadlock_count  = dl_count_q;
  assign core_soft_reset = soft_rst_q;
  assign busy            = (state_q == ST_RECOVER) || (state_q == ST_COOLDOWN);

endmodule

`default_nettype wire

// File: tb/tb_resonator_ddc_deadlock_watchdog.sv
// tb_resonator_ddc_deadlock_watchdog: directed vectors with hand-computed expectations for the deadlock watchdog.
// rev 1.0
`default_nettype none

module tb_resonator_ddc_deadlock_watchdog;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  axis_block_sigs;
  logic        inst_idle;
  logic [15:0] threshold;
  logic        recover_en;
  logic        clear_status;
  logic        block;
  logic        deadlock;
  logic [3:0]  blocked_mask;
  logic [15:0] deadlock_count;
  logic        core_soft_reset;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;
  int csr_cycles;
  int busy_cycles;
  int dl_cycles;

  resonator_ddc_deadlock_watchdog #(
    .N_AXIS     (4),
    .THRESH_W   (16),
    .RST_CYCLES (16),
    .CNT_W      (16)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .axis_block_sigs (axis_block_sigs),
    .inst_idle       (inst_idle),
    .threshold       (threshold),
    .recover_en      (recover_en),
    .clear_status    (clear_status),
    .block           (block),
    .deadlock        (deadlock),
    .blocked_mask    (blocked_mask),
    .deadlock_count  (deadlock_count),
    .core_soft_reset (core_soft_reset),
    .busy            (busy)
  );

  always #5 clock = ~clock;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; axis_block_sigs = 4'h0; inst_idle = 1'b0; threshold = 16'd4;
    recover_en = 1'b0; clear_status = 1'b0;
    tick(3);
    check("rst_block", 32'(block), 32'd0);
    check("rst_deadlock", 32'(deadlock), 32'd0);
    check("rst_mask", 32'(blocked_mask), 32'd0);
    check("rst_count", 32'(deadlock_count), 32'd0);
    check("rst_csr", 32'(core_soft_reset), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    // Basic detection: T=4, single stream held.
    reset = 1'b0; axis_block_sigs = 4'b0100;
    tick();
    check("t1_block_e1", 32'(block), 32'd1);
    tick(3);
    check("t1_dl_e4", 32'(deadlock), 32'd0);
    tick();
    check("t1_dl_e5", 32'(deadlock), 32'd1);
    check("t1_mask", 32'(blocked_mask), 32'h4);
    check("t1_count", 32'(deadlock_count), 32'd1);
    check("t1_csr", 32'(core_soft_reset), 32'd0);
    tick(3);
    check("t1_count_hold", 32'(deadlock_count), 32'd1);
    check("t1_busy_hold", 32'(busy), 32'd0);

    // Clear status, let the FSM fall back to IDLE, then an interrupted pattern.
    clear_status = 1'b1; axis_block_sigs = 4'h0;
    tick();
    clear_status = 1'b0;
    check("clr_dl", 32'(deadlock), 32'd0);
    check("clr_count", 32'(deadlock_count), 32'd0);
    check("clr_mask", 32'(blocked_mask), 32'd0);
    tick(3);
    dl_cycles = 0;
    axis_block_sigs = 4'hF; tick(3);
    dl_cycles += int'(deadlock);
    axis_block_sigs = 4'h0; tick(1);
    dl_cycles += int'(deadlock);
    axis_block_sigs = 4'hF; tick(3);
    dl_cycles += int'(deadlock);
    axis_block_sigs = 4'h0;
    for (int i = 0; i < 6; i++) begin
      tick();
      dl_cycles += int'(deadlock);
    end
    check("t2_no_deadlock", 32'(dl_cycles), 32'd0);
    check("t2_block_low", 32'(block), 32'd0);

    // Recovery: T=2, recover_en=1.
    threshold = 16'd2; recover_en = 1'b1; axis_block_sigs = 4'b0011;
    tick(2);
    check("t3_dl_e2", 32'(deadlock), 32'd0);
    tick();
    check("t3_dl_e3", 32'(deadlock), 32'd1);
    check("t3_mask", 32'(blocked_mask), 32'h3);
    check("t3_csr_e3", 32'(core_soft_reset), 32'd0);
    csr_cycles = 0; busy_cycles = 0;
    for (int e = 4; e <= 37; e++) begin
      tick();
      if (e == 4) check("t3_csr_e4", 32'(core_soft_reset), 32'd1);
      if (e == 20) check("t3_csr_e20", 32'(core_soft_reset), 32'd0);
      csr_cycles += int'(core_soft_reset);
      busy_cycles += int'(busy);
    end
    check("t3_csr_len", 32'(csr_cycles), 32'd16);
    check("t3_busy_len", 32'(busy_cycles), 32'd32);
    check("t3_count_e37", 32'(deadlock_count), 32'd1);
    tick();
    check("t3_count_e38", 32'(deadlock_count), 32'd2);
    tick(2);
    recover_en = 1'b0;
    tick(14);
    check("t3_csr_e54", 32'(core_soft_reset), 32'd1);
    tick();
    check("t3_csr_e55", 32'(core_soft_reset), 32'd0);
    check("t3_busy_e55", 32'(busy), 32'd1);
    tick(15);
    check("t3_busy_e70", 32'(busy), 32'd1);
    tick();
    check("t3_busy_e71", 32'(busy), 32'd0);
    tick(2);
    check("t3_count_e73", 32'(deadlock_count), 32'd3);
    tick(3);
    check("t3_no_recover", 32'(busy), 32'd0);
    check("t3_dl_sticky", 32'(deadlock), 32'd1);

    // Clear coinciding with a fresh DEADLOCK entry.
    axis_block_sigs = 4'h0;
    tick(2);
    axis_block_sigs = 4'b1000;
    tick(2);
    check("t5_pre_count", 32'(deadlock_count), 32'd3);
    clear_status = 1'b1;
    tick();
    clear_status = 1'b0;
    check("t5_dl", 32'(deadlock), 32'd1);
    check("t5_count", 32'(deadlock_count), 32'd1);
    check("t5_mask", 32'(blocked_mask), 32'h8);

    // inst_idle masks blocks.
    axis_block_sigs = 4'h0; clear_status = 1'b1;
    tick();
    clear_status = 1'b0;
    tick();
    threshold = 16'd1; inst_idle = 1'b1; axis_block_sigs = 4'hF;
    dl_cycles = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      dl_cycles += int'(deadlock);
    end
    check("t4_block", 32'(block), 32'd1);
    check("t4_no_deadlock", 32'(dl_cycles), 32'd0);
    inst_idle = 1'b0;
    tick();
    check("t4_thr1_e1", 32'(deadlock), 32'd0);
    tick();
    check("t4_thr1_e2", 32'(deadlock), 32'd1);
    check("t4_thr1_count", 32'(deadlock_count), 32'd1);

    // Reset during RECOVER.
    recover_en = 1'b1;
    tick();
    check("t6_csr_on", 32'(core_soft_reset), 32'd1);
    tick(4);
    check("t6_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t6_csr_off", 32'(core_soft_reset), 32'd0);
    check("t6_busy_off", 32'(busy), 32'd0);
    check("t6_dl_off", 32'(deadlock), 32'd0);
    check("t6_count_off", 32'(deadlock_count), 32'd0);
    check("t6_mask_off", 32'(blocked_mask), 32'd0);

    // threshold = 0 disables detection.
    threshold = 16'd0;
    dl_cycles = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      dl_cycles += int'(deadlock);
    end
    check("t7_thr0", 32'(dl_cycles), 32'd0);
    check("t7_block", 32'(block), 32'd1);

    // Threshold raised below the running count: no fire until re-count.
    threshold = 16'd5;
    dl_cycles = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      dl_cycles += int'(deadlock);
    end
    check("t8_exceeded", 32'(dl_cycles), 32'd0);
    axis_block_sigs = 4'h0;
    tick(2);
    axis_block_sigs = 4'h2;
    tick(5);
    check("t8_e5", 32'(deadlock), 32'd0);
    tick();
    check("t8_e6", 32'(deadlock), 32'd1);
    check("t8_mask", 32'(blocked_mask), 32'h2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
